// File: rtl/sign_cmp_pipe.sv
// sign_cmp_pipe: two-stage, valid/ready pipelined magnitude comparator.
//
// The number format is selected per beat and captured with the operands:
//   in_mode 00 unsigned, 01 two's complement, 10 sign-magnitude, 11 same as 01.
// Each operand is normalised to a WIDTH+1-bit two's complement value in stage 1.
// Stage 2 does a signed compare of those values and registers the flags.
// In sign-magnitude, -0 and +0 normalise to the same value.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in_ready is combinational from out_ready
//   in_a, in_b           operands, WIDTH bits
//   in_mode              format select, MODE_W bits
//   out_valid/out_ready  result handshake
//   out_agtb, out_aeqb,  relation flags for A versus B;
//   out_altb, out_ageb   they are meaningful only while out_valid = 1
//
// Optional build: `define SIGN_CMP_PIPE_MAX_EN adds the running-maximum tracker:
//   max_clr  in   clears the tracker; it wins over an update in the same cycle
//   max_val  out  largest normalised A seen on output transfers (WIDTH+1 bits)
//   max_vld  out  max_val holds at least one beat since reset or the last clear
module sign_cmp_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned MODE_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [MODE_W-1:0] in_mode,
`ifdef SIGN_CMP_PIPE_MAX_EN
    input  logic              max_clr,
    output logic [WIDTH:0]    max_val,
    output logic              max_vld,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_agtb,
    output logic              out_aeqb,
    output logic              out_altb,
    output logic              out_ageb
);

    logic           s1_valid_q;
    logic [WIDTH:0] s1_a_q;
    logic [WIDTH:0] s1_b_q;
    logic           s2_valid_q;
    logic           agtb_q;
    logic           aeqb_q;
    logic           altb_q;
    logic           s2_adv;
    logic           s1_adv;
    logic [WIDTH:0] norm_a;
    logic [WIDTH:0] norm_b;
    logic           cmp_gt;
    logic           cmp_eq;

    // Extends an operand to WIDTH+1 bits of two's complement, as selected by mode.
    function automatic logic [WIDTH:0] normalise(input logic [WIDTH-1:0]  x,
                                                 input logic [MODE_W-1:0] mode);
        logic [WIDTH:0] mag;
        logic [WIDTH:0] res;
        mag = {2'b00, x[WIDTH-2:0]};
        res = {x[WIDTH-1], x};
        case (mode)
            2'b00:   res = {1'b0, x};
            // Negating a zero magnitude gives zero, so -0 normalises to +0.
            2'b10:   res = x[WIDTH-1] ? ({(WIDTH + 1){1'b0}} - mag) : mag;
            default: res = {x[WIDTH-1], x};
        endcase
        return res;
    endfunction

    // Stage 2 can take a new beat when it is empty or its beat leaves this cycle.
    // The ready path is combinational from out_ready, so a full pipe still streams.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv;
        norm_a   = normalise(in_a, in_mode);
        norm_b   = normalise(in_b, in_mode);
        cmp_gt   = $signed(s1_a_q) > $signed(s1_b_q);
        cmp_eq   = s1_a_q == s1_b_q;
    end

    // Stage 1: normalise and capture a beat on each input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q <= norm_a;
                s1_b_q <= norm_b;
            end
        end
    end

    // Stage 2: register the flags. They change only when a real beat moves in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            agtb_q     <= 1'b0;
            aeqb_q     <= 1'b0;
            altb_q     <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                agtb_q <= cmp_gt;
                aeqb_q <= cmp_eq;
                altb_q <= !cmp_gt && !cmp_eq;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_agtb  = agtb_q;
    assign out_aeqb  = aeqb_q;
    assign out_altb  = altb_q;
    assign out_ageb  = agtb_q | aeqb_q;

`ifdef SIGN_CMP_PIPE_MAX_EN
    logic [WIDTH:0] s2_a_q;
    logic [WIDTH:0] max_val_q;
    logic           max_vld_q;
    logic           out_xfer;

    assign out_xfer = s2_valid_q && out_ready;

    // Stage 2 keeps the normalised A of its beat for the max tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_a_q <= '0;
        end else if (s2_adv && s1_valid_q) begin
            s2_a_q <= s1_a_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val_q <= '0;
            max_vld_q <= 1'b0;
        end else if (max_clr) begin
            max_vld_q <= 1'b0;
        end else if (out_xfer) begin
            if (!max_vld_q || ($signed(s2_a_q) > $signed(max_val_q))) begin
                max_val_q <= s2_a_q;
            end
            max_vld_q <= 1'b1;
        end
    end

    assign max_val = max_val_q;
    assign max_vld = max_vld_q;
`endif

endmodule

// File: tb/tb_sign_cmp_pipe.sv
module tb_sign_cmp_pipe;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [1:0]       in_mode = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_agtb;
    logic             out_aeqb;
    logic             out_altb;
    logic             out_ageb;
`ifdef SIGN_CMP_PIPE_MAX_EN
    logic             max_clr = 1'b0;
    logic [WIDTH:0]   max_val;
    logic             max_vld;
`endif

    sign_cmp_pipe #(.WIDTH(WIDTH), .MODE_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
`ifdef SIGN_CMP_PIPE_MAX_EN
        .max_clr   (max_clr),
        .max_val   (max_val),
        .max_vld   (max_vld),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_agtb  (out_agtb),
        .out_aeqb  (out_aeqb),
        .out_altb  (out_altb),
        .out_ageb  (out_ageb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected flags are packed {gt, eq, lt, ge}.
    localparam logic [3:0] GT = 4'b1001;
    localparam logic [3:0] EQ = 4'b0101;
    localparam logic [3:0] LT = 4'b0010;

    typedef struct {
        logic [3:0] flags;
        int         acc;
        bit         lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_acc  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("one_hot", 32'($countones({out_agtb, out_aeqb, out_altb})), 32'd1);
            if (out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: result with empty scoreboard at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("flags", 32'({out_agtb, out_aeqb, out_altb, out_ageb}), 32'(e.flags));
                    if (e.lat) check("latency", 32'(cyc - e.acc), 32'd2);
                end
            end
        end
    end

    // Drives a beat and returns at the negedge before the edge that accepts it.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                        input logic [3:0] f, input bit lat);
        int t = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end else begin
            sb.push_back('{f, cyc, lat});
            n_acc++;
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        idle();
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Reset state.
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", 32'({out_agtb, out_aeqb, out_altb, out_ageb}), 32'd0);
`ifdef SIGN_CMP_PIPE_MAX_EN
        check("rst_max_val", 32'(max_val), 32'd0);
        check("rst_max_vld", 32'(max_vld), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors, streamed back to back with out_ready = 1.
        send(8'h80, 8'h7F, 2'b01, LT, 1'b1);  // -128 < 127
        send(8'h80, 8'h7F, 2'b00, GT, 1'b1);  // 128 > 127
        send(8'h80, 8'h00, 2'b10, EQ, 1'b1);  // -0 == +0
        send(8'h85, 8'h83, 2'b10, LT, 1'b1);  // -5 < -3
        send(8'hFF, 8'h01, 2'b11, LT, 1'b1);  // reserved mode as two's complement
        send(8'h05, 8'h85, 2'b10, GT, 1'b1);  // 5 > -5
        send(8'hFF, 8'hFF, 2'b00, EQ, 1'b1);
        send(8'h7F, 8'h80, 2'b01, GT, 1'b1);
        send(8'hFF, 8'h81, 2'b10, LT, 1'b1);  // -127 < -1
        send(8'h7F, 8'hFF, 2'b10, GT, 1'b1);  // 127 > -127
        drain();

        // Backpressure: four beats, out_ready low for five cycles.
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                send(8'h01, 8'h02, 2'b00, LT, 1'b0);
                send(8'h03, 8'h03, 2'b00, EQ, 1'b0);
                send(8'hFF, 8'h00, 2'b00, GT, 1'b0);
                send(8'h00, 8'hFF, 2'b00, LT, 1'b0);
                idle();
            end
            begin
                int base;
                base = n_acc;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (i >= 2) begin
                        check("bp_valid", 32'(out_valid), 32'd1);
                        check("bp_flags_hold",
                              32'({out_agtb, out_aeqb, out_altb, out_ageb}), 32'(LT));
                    end
                end
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_accepted", 32'(n_acc - base), 32'd2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight.
        send(8'h10, 8'h20, 2'b00, LT, 1'b0);
        send(8'h30, 8'h20, 2'b00, GT, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_flags", 32'({out_agtb, out_aeqb, out_altb, out_ageb}), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_no_stale", 32'(out_valid), 32'd0);
        end
        send(8'hFE, 8'hFD, 2'b01, GT, 1'b1);  // -2 > -3
        drain();

`ifdef SIGN_CMP_PIPE_MAX_EN
        // Max tracker: clear, then A = 5, -16, 127, 16 in two's complement.
        @(posedge clk);
        #1;
        max_clr = 1'b1;
        @(posedge clk);
        #1;
        max_clr = 1'b0;
        check("max_clr_vld", 32'(max_vld), 32'd0);
        send(8'h05, 8'h00, 2'b01, GT, 1'b1);
        send(8'hF0, 8'h00, 2'b01, LT, 1'b1);
        send(8'h7F, 8'h00, 2'b01, GT, 1'b1);
        send(8'h10, 8'h00, 2'b01, GT, 1'b1);
        drain();
        check("max_val", 32'(max_val), 32'h07F);
        check("max_vld", 32'(max_vld), 32'd1);
        @(posedge clk);
        #1;
        max_clr = 1'b1;
        @(posedge clk);
        #1;
        max_clr = 1'b0;
        check("max_clr_vld2", 32'(max_vld), 32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sign_cmp_pipe.md
Name: sign_cmp_pipe

Overview:
- Parametrised, pipelined magnitude comparator for WIDTH-bit operands A and B.
- Per-beat selectable number format: unsigned, two's complement, or sign-magnitude. Sign-magnitude is normalised to two's complement before comparison, and -0 equals +0.
- Two-stage valid/ready pipeline with full backpressure. Sits between operand producers and downstream decision logic in the signed-compare datapath.
- Produces four registered relation flags per beat: GT, EQ, LT, GE.

Parameters:
- WIDTH, 8, operand width in bits, minimum 2.
- MODE_W, 2, width of the per-beat format select. Fixed; not to be overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_mode  in  MODE_W  format: 00 unsigned, 01 two's complement, 10 sign-magnitude, 11 reserved (treated as 01).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_agtb  out  1  A > B.
- out_aeqb  out  1  A == B.
- out_altb  out  1  A < B.
- out_ageb  out  1  A >= B.

Behaviour:
- Reset (asynchronous assert, synchronous-safe release):
  - s1_valid, s2_valid, out_valid = 0.
  - All four flags = 0.
  - Data registers are cleared to 0.
  - A reset mid-operation discards all in-flight beats; nothing is replayed after release.
- Transfers:
  - Input transfer occurs when in_valid and in_ready are both 1.
  - Output transfer occurs when out_valid and out_ready are both 1.
- Stage 1 (normalise): captures A, B and mode per beat, so a mode change between beats affects only later beats. Each operand is extended to WIDTH+1 bits:
  - unsigned: zero-extend.
  - two's complement: sign-extend.
  - sign-magnitude: if MSB = 0, zero-extend the magnitude. If MSB = 1, negate the zero-extended magnitude to WIDTH+1 bits. Magnitude 0 with sign 1 yields 0.
- Stage 2 (compare): signed compare of the two WIDTH+1-bit values. Result is registered into the flags.
  - Exactly one of agtb, aeqb, altb is 1 while out_valid = 1.
  - ageb = agtb | aeqb.
- Latency: a beat accepted in cycle N presents out_valid in cycle N+2 when there is no backpressure.
- Throughput: one beat per cycle when out_ready is held at 1.
- Flow control:
  - s2 advances when !s2_valid or out_ready.
  - s1 advances when !s1_valid or s2 advances.
  - in_ready = !s1_valid or s2 advances. in_ready is combinational from out_ready; no register is placed in the ready path.
- Backpressure: while out_valid = 1 and out_ready = 0, all flags and out_valid hold stable. At most 2 beats are in flight; in_ready drops to 0 once both stages are full.
- Simultaneous input and output transfer in the same cycle with both stages full: both stages shift and nothing is lost or duplicated.
- in_valid may be asserted without regard to in_ready. Data is not sampled unless in_ready = 1.
- Flag outputs while out_valid = 0 hold their last value and have no meaning; consumers qualify them with out_valid.

Optional Feature:
- Macro: SIGN_CMP_PIPE_MAX_EN.
- When defined, the block adds:
  - input max_clr (1 bit).
  - output max_val (WIDTH+1 bits, normalised two's complement).
  - output max_vld (1 bit).
- Max tracking:
  - On each output transfer, max_val updates to the greater of max_val and the A operand of that beat, compared as normalised signed values.
  - The first output transfer after reset or clear loads the A operand unconditionally and sets max_vld = 1.
  - max_clr = 1 sets max_vld = 0 on the next edge and has priority over a same-cycle update.
  - Reset values: max_val = 0, max_vld = 0.
- When not defined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Mode 01, WIDTH=8: A=0x80, B=0x7F, out_ready=1 -> out_altb=1 and out_ageb=0, exactly 2 cycles after acceptance.
- Same operands A=0x80, B=0x7F in mode 00 -> out_agtb=1, out_ageb=1.
- Mode 10: A=0x80 (-0), B=0x00 -> out_aeqb=1. Then A=0x85 (-5), B=0x83 (-3) -> out_altb=1.
- Backpressure: stream 4 beats with out_ready=0 for 5 cycles. Expect in_ready=0 after 2 accepted beats and flags stable. After releasing out_ready, all 4 results appear in order with none dropped or duplicated.
- Reset mid-stream: rst_n asserted low with 2 beats in flight -> out_valid=0 immediately. After release, no stale results appear; a new beat yields correct flags at +2 cycles.
- With SIGN_CMP_PIPE_MAX_EN, mode 01: A sequence 0x05, 0xF0, 0x7F, 0x10 -> max_val=0x07F, max_vld=1. Pulse max_clr -> max_vld=0 on the next edge.
